// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle, word-addressed data memory for the CPU
// load/store interface. A request is accepted in IDLE, held for WAIT_CYCLES
// wait states, then committed (store) or returned (load) with a one-cycle
// Ready pulse. Illegal requests complete with Error=1 and touch nothing.
// Optional feature macro: DMEM_STATS_EN adds saturating load/store/error
// counters (LoadCount, StoreCount, ErrCount).
module data_mem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Req,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Busy,
   output logic        Error
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] LoadCount,
   output logic [15:0] StoreCount,
   output logic [15:0] ErrCount
`endif
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // A request is legal only with exactly one strobe and an in-range address
   // (full 32-bit compare, so high address bits never alias into the array).
   function automatic logic is_legal(input logic [31:0] addr,
                                     input logic        rd,
                                     input logic        wr);
      return (addr < DEPTH_W) && (rd ^ wr);
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_nxt_s;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        rd_r;
   logic        wr_r;
   logic [31:0] read_data_r;
   logic        ready_r;
   logic        error_r;

   logic [31:0] op_addr_s;
   logic [31:0] op_wdata_s;
   logic        op_rd_s;
   logic        op_wr_s;
   logic        enter_resp_s;
   logic        legal_s;
   logic        do_load_s;
   logic        do_store_s;
   logic [31:0] mem_rd_s;

   logic [31:0] mem [0:DEPTH-1];

   // Next-state, wait counter and operand selection. With zero wait states the
   // request commits on its acceptance edge, so the live inputs are used in IDLE.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      enter_resp_s = 1'b0;
      op_addr_s    = addr_r;
      op_wdata_s   = wdata_r;
      op_rd_s      = rd_r;
      op_wr_s      = wr_r;
      case (state_r)
         S_IDLE: begin
            op_addr_s  = Address;
            op_wdata_s = WriteData;
            op_rd_s    = MemRead;
            op_wr_s    = MemWrite;
            if (Req) begin
               if (WAIT_CYCLES == 32'd0) begin
                  state_nxt_s  = S_RESP;
                  enter_resp_s = 1'b1;
               end else begin
                  state_nxt_s = S_WAIT;
                  cnt_nxt_s   = 4'd0;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_r == WAIT_LAST) begin
               state_nxt_s  = S_RESP;
               enter_resp_s = 1'b1;
               cnt_nxt_s    = 4'd0;
            end else begin
               cnt_nxt_s = cnt_r + 4'd1;
            end
         end
         S_RESP: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // Commit decode for the edge that enters RESP.
   always_comb begin
      legal_s    = is_legal(op_addr_s, op_rd_s, op_wr_s);
      do_load_s  = enter_resp_s & legal_s & op_rd_s;
      do_store_s = enter_resp_s & legal_s & op_wr_s;
      mem_rd_s   = mem[op_addr_s[AW-1:0]];
   end

   // Control state, captured request and registered response outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r     <= S_IDLE;
         cnt_r       <= 4'd0;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         rd_r        <= 1'b0;
         wr_r        <= 1'b0;
         read_data_r <= 32'd0;
         ready_r     <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (state_r == S_IDLE && Req) begin
            addr_r  <= Address;
            wdata_r <= WriteData;
            rd_r    <= MemRead;
            wr_r    <= MemWrite;
         end
         if (do_load_s) begin
            read_data_r <= mem_rd_s;
         end
         ready_r <= enter_resp_s;
         error_r <= enter_resp_s & ~legal_s;
      end
   end

   // Storage array; deliberately not reset so contents survive RST.
   always_ff @(posedge CLK) begin
      if (do_store_s) begin
         mem[op_addr_s[AW-1:0]] <= op_wdata_s;
      end
   end

   assign ReadData = read_data_r;
   assign Ready    = ready_r;
   assign Error    = error_r;
   assign Busy     = (state_r != S_IDLE);

`ifdef DMEM_STATS_EN
   logic [15:0] load_cnt_r;
   logic [15:0] store_cnt_r;
   logic [15:0] err_cnt_r;

   // Saturating completion counters, bumped on the edge entering RESP.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         load_cnt_r  <= 16'd0;
         store_cnt_r <= 16'd0;
         err_cnt_r   <= 16'd0;
      end else begin
         if (do_load_s && load_cnt_r != 16'hFFFF) begin
            load_cnt_r <= load_cnt_r + 16'd1;
         end
         if (do_store_s && store_cnt_r != 16'hFFFF) begin
            store_cnt_r <= store_cnt_r + 16'd1;
         end
         if (enter_resp_s && !legal_s && err_cnt_r != 16'hFFFF) begin
            err_cnt_r <= err_cnt_r + 16'd1;
         end
      end
   end

   assign LoadCount  = load_cnt_r;
   assign StoreCount = store_cnt_r;
   assign ErrCount   = err_cnt_r;
`endif

endmodule
